keypad_digit_buffer: RTL
========================

# keypad_digit_buffer

Parametrised keypad-entry and multi-digit display block for the ECE272 FPGA designs. It debounces a raw one-hot button bank and decodes the accepted key into a code. It applies digit, backspace and clear commands to an internal digit buffer. It time-multiplexes the newest buffered digits onto a shared seven-segment bus. It runs from the 2.08 MHz oscillator clock and replaces ad-hoc button decoding plus single-digit display at the top level.

## Interface
- NUM_BUTTONS, 16: raw button inputs, one per key code (index = code); 2..16
- DEPTH, 8: digit buffer entries
- NUM_DIGITS, 4: display digits scanned; 1 ≤ NUM_DIGITS ≤ DEPTH
- DEBOUNCE_CYCLES, 20800: stable cycles to accept a press or release (10 ms @ 2.08 MHz)
- SCAN_CYCLES, 2080: cycles each digit stays selected
- clk_i  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- buttons  in  NUM_BUTTONS  raw active-high buttons, asynchronous to clk_i
- clear_i  in  1  synchronous buffer clear, same effect as KEY_CLEAR
- sevenseg  out  7  active-high segments, bit0=a … bit6=g
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable
- key_valid_o  out  1  one-cycle pulse per accepted key
- key_code_o  out  4  code of last accepted key, held between pulses
- count_o  out  $clog2(DEPTH+1)  digits currently stored
- full_o  out  1  count_o == DEPTH

## Operation
- Inputs pass through a 2-flop synchroniser before any use.
- Debounce FSM:
  - IDLE: exactly one button high → DEB_PRESS, latch index; zero or multiple buttons → stay.
  - DEB_PRESS: same single button for DEBOUNCE_CYCLES consecutive cycles → HELD and pulse key_valid_o; any change → IDLE.
  - HELD: all buttons low → DEB_REL; extra buttons pressed are ignored.
  - DEB_REL: all low for DEBOUNCE_CYCLES → IDLE; any press → HELD, counter cleared.
- Key actions on a key_valid_o pulse:
  - Codes 0-9: push. The buffer shifts up, the new digit enters entry 0, count+1. When full, the key is rejected and the buffer is unchanged.
  - 10 (KEY_BACKSPACE): pop. The buffer shifts down, count−1. Empty → no-op.
  - 11 (KEY_CLEAR): count=0.
  - 12-15: no buffer effect; key_valid_o still pulses.
- clear_i and a key action in the same cycle: clear wins.
- Display digit i shows entry i when i < count_o; otherwise it is blank (0000000).
- Exception: count_o=0 shows "0" on digit 0.
- Scan index advances every SCAN_CYCLES and wraps NUM_DIGITS−1 → 0.

## Timing
- Reset values:
  - digit_sel = 1 (digit 0)
  - sevenseg = 7'b0111111 ("0")
  - key_valid_o = 0, key_code_o = 0
  - count_o = 0, full_o = 0
  - FSM = IDLE; all counters and buffer entries = 0
- Press to pulse: the synchronised button must be stable for DEBOUNCE_CYCLES consecutive cycles. key_valid_o asserts on the following edge.
- key_code_o updates on the same edge that key_valid_o asserts.
- count_o, full_o and buffer contents update on the edge at the end of the pulse cycle.
- Display refresh: sevenseg and digit_sel are registered together and always aligned. A buffer change appears at the next scan of the affected digit.
- Reset mid-debounce or mid-scan: all state returns to reset values. A button held through reset must re-debounce from IDLE.
- Counters saturate or wrap exactly at their terminal value (DEBOUNCE_CYCLES−1, SCAN_CYCLES−1); there are no off-by-one extra cycles.

## Structure
- Package keypad_pkg holds:
  - KEY_BACKSPACE = 4'd10 and KEY_CLEAR = 4'd11
  - debounce state enum {IDLE, DEB_PRESS, HELD, DEB_REL}
  - function seg_of(logic [3:0]) returning 0-9 active-high patterns
- Sub-module keypad_debouncer contains the synchroniser, debounce FSM and code encoder. Its outputs are key_valid and key_code.
- The buffer, counters and scanner stay in the top module.

## Test plan
- Press button 5 for DEBOUNCE_CYCLES+10 cycles, then release → one key_valid_o pulse, key_code_o=5, count_o=1, digit 0 shows 7'b1101101.
- Glitch button 3 high for DEBOUNCE_CYCLES−1 cycles, then low → no pulse, count_o=0.
- Push digits 1..8 with DEPTH=8, then push 9 → full_o=1; the ninth key pulses but entries are unchanged. Digits 0-3 show 8,7,6,5.
- Enter 4, 2, then press button 10 → count_o=1, digit 0 shows "4". A second backspace leaves count_o=0 and digit 0 shows "0". A third backspace is a no-op.
- Hold buttons 1 and 2 together → no pulse. Assert clear_i in the same cycle as a push of 7 → count_o=0.
- Assert reset_n low while in HELD mid-scan → outputs return to reset values. The still-held button produces a new pulse only after a full DEBOUNCE_CYCLES.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key codes, debounce states and the seven-segment decoder for the
// keypad digit buffer.
package keypad_pkg;

    localparam logic [3:0] KEY_BACKSPACE = 4'd10;
    localparam logic [3:0] KEY_CLEAR     = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_REL
    } deb_state_e;

    // Active-high segments, bit0 = a ... bit6 = g; non-decimal codes are blank.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b0111111;
            4'd1:    seg_of = 7'b0000110;
            4'd2:    seg_of = 7'b1011011;
            4'd3:    seg_of = 7'b1001111;
            4'd4:    seg_of = 7'b1100110;
            4'd5:    seg_of = 7'b1101101;
            4'd6:    seg_of = 7'b1111101;
            4'd7:    seg_of = 7'b0000111;
            4'd8:    seg_of = 7'b1111111;
            4'd9:    seg_of = 7'b1101111;
            default: seg_of = 7'b0000000;
        endcase
    endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// Synchronises the raw button bank, debounces a single pressed key and
// emits a one-cycle key_valid pulse together with the key's code.
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int NUM_BUTTONS     = 16,
    parameter int DEBOUNCE_CYCLES = 20800
) (
    input  logic                   clk_i,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic                   key_valid,
    output logic [3:0]             key_code
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NUM_BUTTONS-1:0] sync1, sync2;
    logic [4:0]             ones;
    logic [3:0]             hot_idx;
    logic                   one_hot;

    deb_state_e    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    idx, idx_n;
    logic          valid_n;
    logic [3:0]    code_n;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
        end
    end

    always_comb begin
        ones    = '0;
        hot_idx = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (sync2[i]) begin
                ones    = ones + 5'd1;
                hot_idx = 4'(i);
            end
        end
        one_hot = (ones == 5'd1);
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            key_valid <= valid_n;
            key_code  <= code_n;
        end
    end

    // The cycle that starts a debounce window is counted as its first
    // stable cycle, so a window closes after exactly DEBOUNCE_CYCLES.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        valid_n = 1'b0;
        code_n  = key_code;
        case (state)
            IDLE: begin
                if (one_hot) begin
                    state_n = DEB_PRESS;
                    idx_n   = hot_idx;
                    cnt_n   = CW'(1);
                end
            end
            DEB_PRESS: begin
                if (!one_hot || hot_idx != idx) begin
                    state_n = IDLE;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    state_n = HELD;
                    valid_n = 1'b1;
                    code_n  = idx;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HELD: begin
                if (sync2 == '0) begin
                    state_n = DEB_REL;
                    cnt_n   = CW'(1);
                end
            end
            DEB_REL: begin
                if (sync2 != '0) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/keypad_digit_buffer.sv
// Keypad entry into a shift-register digit buffer with a time-multiplexed
// seven-segment display of the newest NUM_DIGITS entries.
module keypad_digit_buffer
    import keypad_pkg::*;
#(
    parameter int NUM_BUTTONS     = 16,
    parameter int DEPTH           = 8,
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 20800,
    parameter int SCAN_CYCLES     = 2080
) (
    input  logic                       clk_i,
    input  logic                       reset_n,
    input  logic [NUM_BUTTONS-1:0]     buttons,
    input  logic                       clear_i,
    output logic [6:0]                 sevenseg,
    output logic [NUM_DIGITS-1:0]      digit_sel,
    output logic                       key_valid_o,
    output logic [3:0]                 key_code_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    logic          key_valid;
    logic [3:0]    key_code;
    logic [3:0]    entries [DEPTH];
    logic [CW-1:0] count;
    logic [SW-1:0] scnt;
    logic [DW-1:0] scan_idx, scan_nxt;
    logic [6:0]    seg_nxt;

    keypad_debouncer #(
        .NUM_BUTTONS     (NUM_BUTTONS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk_i     (clk_i),
        .reset_n   (reset_n),
        .buttons   (buttons),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    assign key_valid_o = key_valid;
    assign key_code_o  = key_code;
    assign count_o     = count;
    assign full_o      = (count == CW'(DEPTH));

    // clear_i is already in the clk_i domain and overrides any key action.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (clear_i) begin
            count <= '0;
        end else if (key_valid) begin
            if (key_code <= 4'd9) begin
                if (!full_o) begin
                    for (int i = DEPTH - 1; i > 0; i--) entries[i] <= entries[i-1];
                    entries[0] <= key_code;
                    count      <= count + CW'(1);
                end
            end else if (key_code == KEY_BACKSPACE) begin
                if (count != '0) begin
                    for (int i = 0; i < DEPTH - 1; i++) entries[i] <= entries[i+1];
                    entries[DEPTH-1] <= '0;
                    count            <= count - CW'(1);
                end
            end else if (key_code == KEY_CLEAR) begin
                count <= '0;
            end
        end
    end

    always_comb begin
        scan_nxt = (scan_idx == DW'(NUM_DIGITS - 1)) ? '0 : scan_idx + DW'(1);
        seg_nxt  = 7'b0000000;
        if (int'(scan_nxt) < int'(count))
            seg_nxt = seg_of(entries[AW'(scan_nxt)]);
        else if (count == '0 && scan_nxt == '0)
            seg_nxt = seg_of(4'd0);
    end

    // Segments and select load together at each scan step, so they never skew.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            scnt      <= '0;
            scan_idx  <= '0;
            digit_sel <= NUM_DIGITS'(1);
            sevenseg  <= 7'b0111111;
        end else if (scnt == SW'(SCAN_CYCLES - 1)) begin
            scnt      <= '0;
            scan_idx  <= scan_nxt;
            digit_sel <= NUM_DIGITS'(1) << scan_nxt;
            sevenseg  <= seg_nxt;
        end else begin
            scnt <= scnt + SW'(1);
        end
    end

endmodule
